wb_regfile: RTL

- Consumer end of the execute-stage result bus (write address, write enable, write data).
- Registers that result for one cycle (writeback pipeline register), commits it to the 32x32 general register file, and serves the decode stage's two read ports.
- Read ports forward from both the live execute result and the pending writeback result, so back-to-back dependent instructions never read stale data.

---
 rtl/wb_regfile_pkg.sv | 14 +
 rtl/wb_regfile_regfile.sv | 70 +++++++
 rtl/wb_regfile.sv | 79 +++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared widths, zero word and signal active levels for the writeback/register-file slice.
package wb_regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    localparam logic WRITE_EN   = 1'b1;
    localparam logic READ_EN    = 1'b1;
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/wb_regfile_regfile.sv
// 32-entry general register file: one write port fed by writeback, two read ports
// that forward from the live execute result and the pending writeback result.
module wb_regfile_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        ex_we,
    input  logic [ADDR_W-1:0]           ex_waddr,
    input  logic [DATA_W-1:0]           ex_wdata,
    input  logic [1:0]                  re,
    input  logic [1:0][ADDR_W-1:0]      raddr,
    output logic [1:0][DATA_W-1:0]      rdata
);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];

    // Reset is asynchronous, so the array lives in flops rather than block RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we == WRITE_EN && waddr != '0) begin
            regs_reg[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_sel(
        input logic              rst_l,
        input logic              rd_en,
        input logic [ADDR_W-1:0] rd_addr,
        input logic [DATA_W-1:0] arr_data,
        input logic              ex_en,
        input logic [ADDR_W-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_data,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] res;
        res = '0;
        if (rst_l == RST_ACTIVE || rd_en != READ_EN || rd_addr == '0) begin
            res = '0;
        end else if (ex_en == WRITE_EN && ex_addr == rd_addr) begin
            res = ex_data;  // youngest result wins
        end else if (wb_en == WRITE_EN && wb_addr == rd_addr) begin
            res = wb_data;
        end else begin
            res = arr_data;
        end
        return res;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = read_sel(rst, re[gi], raddr[gi], regs_reg[raddr[gi]],
                                        ex_we, ex_waddr, ex_wdata, we, waddr, wdata);
        end
    endgenerate

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: one-cycle pipeline register (flush over stall) feeding the register file.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    logic [ADDR_W-1:0] wb_wd_reg;
    logic              wb_wreg_reg;
    logic [DATA_W-1:0] wb_wdata_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wb_wd_reg    <= '0;
            wb_wreg_reg  <= 1'b0;
            wb_wdata_reg <= '0;
        end else if (flush_i) begin
            wb_wd_reg    <= '0;
            wb_wreg_reg  <= 1'b0;
            wb_wdata_reg <= '0;
        end else if (!stall_i) begin
            wb_wd_reg    <= ex_wd_i;
            wb_wreg_reg  <= ex_wreg_i;
            wb_wdata_reg <= ex_wdata_i;
        end
    end

    assign wb_wd_o    = wb_wd_reg;
    assign wb_wreg_o  = wb_wreg_reg;
    assign wb_wdata_o = wb_wdata_reg;

    logic [1:0]             re_vec;
    logic [1:0][ADDR_W-1:0] raddr_vec;
    logic [1:0][DATA_W-1:0] rdata_vec;

    assign re_vec    = {re2_i, re1_i};
    assign raddr_vec = {raddr2_i, raddr1_i};
    assign rdata1_o  = rdata_vec[0];
    assign rdata2_o  = rdata_vec[1];

    // Writes keep firing while stalled; rewriting the held value is harmless.
    wb_regfile_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_wreg_reg),
        .waddr    (wb_wd_reg),
        .wdata    (wb_wdata_reg),
        .ex_we    (ex_wreg_i),
        .ex_waddr (ex_wd_i),
        .ex_wdata (ex_wdata_i),
        .re       (re_vec),
        .raddr    (raddr_vec),
        .rdata    (rdata_vec)
    );

endmodule
